// File: rtl/turret_controller.sv
// turret_controller: turns one-cycle input-controller action pulses into turret
// heading, fire-mode and paced projectile spawn requests (valid/ready handshake).
module turret_controller #(
    parameter int unsigned DIR_BITS  = 3,
    parameter int unsigned BURST_LEN = 3,
    parameter int unsigned BURST_GAP = 4,
    parameter int unsigned COOLDOWN  = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fire,
    input  logic                change_mode,
    input  logic                rotate,
    input  logic                rotate_right,
    input  logic                frame_tick,
    input  logic                spawn_ready,
    output logic                spawn_valid,
    output logic [DIR_BITS-1:0] spawn_dir,
    output logic [DIR_BITS-1:0] heading,
    output logic                burst_mode,
    output logic                busy
);

    localparam int unsigned SHOT_W  = $clog2(BURST_LEN + 1);
    localparam int unsigned CNT_MAX = (BURST_GAP > COOLDOWN) ? BURST_GAP : COOLDOWN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPAWN = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_COOL  = 2'd3;

    logic [1:0]          r_state;
    logic [SHOT_W-1:0]   r_shots_left;
    logic [CNT_W-1:0]    r_cnt;
    logic [DIR_BITS-1:0] r_heading;
    logic [DIR_BITS-1:0] r_spawn_dir;
    logic                r_burst_mode;
    logic                r_spawn_valid;
    logic                r_busy;

    logic [1:0]          w_state_nxt;
    logic [SHOT_W-1:0]   w_shots_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DIR_BITS-1:0] w_heading_nxt;
    logic [DIR_BITS-1:0] w_spawn_dir_nxt;
    logic                w_burst_mode_nxt;
    logic                w_spawn_valid_nxt;
    logic                w_busy_nxt;

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_shots_left  <= '0;
            r_cnt         <= '0;
            r_heading     <= '0;
            r_spawn_dir   <= '0;
            r_burst_mode  <= 1'b0;
            r_spawn_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shots_left  <= w_shots_nxt;
            r_cnt         <= w_cnt_nxt;
            r_heading     <= w_heading_nxt;
            r_spawn_dir   <= w_spawn_dir_nxt;
            r_burst_mode  <= w_burst_mode_nxt;
            r_spawn_valid <= w_spawn_valid_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // Next-state, heading, mode and shot pacing; spawn_dir samples the pre-rotation heading.
    always_comb begin
        w_state_nxt      = r_state;
        w_shots_nxt      = r_shots_left;
        w_cnt_nxt        = r_cnt;
        w_heading_nxt    = r_heading;
        w_spawn_dir_nxt  = r_spawn_dir;
        w_burst_mode_nxt = r_burst_mode;

        if (rotate) begin
            w_heading_nxt = rotate_right ? (r_heading + DIR_BITS'(1))
                                         : (r_heading - DIR_BITS'(1));
        end

        case (r_state)
            ST_IDLE: begin
                if (change_mode) begin
                    w_burst_mode_nxt = ~r_burst_mode;
                end
                if (fire) begin
                    w_state_nxt     = ST_SPAWN;
                    w_shots_nxt     = r_burst_mode ? SHOT_W'(BURST_LEN) : SHOT_W'(1);
                    w_spawn_dir_nxt = r_heading;
                end
            end
            ST_SPAWN: begin
                if (r_spawn_valid && spawn_ready) begin
                    w_shots_nxt = r_shots_left - SHOT_W'(1);
                    if (r_shots_left == SHOT_W'(1)) begin
                        w_state_nxt = ST_COOL;
                        w_cnt_nxt   = CNT_W'(COOLDOWN);
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = CNT_W'(BURST_GAP);
                    end
                end
            end
            ST_GAP: begin
                if (frame_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt     = ST_SPAWN;
                        w_spawn_dir_nxt = r_heading;
                    end
                end
            end
            ST_COOL: begin
                if (frame_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_spawn_valid_nxt = (w_state_nxt == ST_SPAWN);
        w_busy_nxt        = (w_state_nxt != ST_IDLE);
    end

    assign spawn_valid = r_spawn_valid;
    assign spawn_dir   = r_spawn_dir;
    assign heading     = r_heading;
    assign burst_mode  = r_burst_mode;
    assign busy        = r_busy;

endmodule

// File: tb/tb_turret_controller.sv
// Directed bench for turret_controller: expected shot headings are queued by the
// stimulus and checked by a handshake monitor; state outputs are checked inline.
module tb_turret_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       fire, change_mode, rotate, rotate_right, frame_tick, spawn_ready;
    logic       spawn_valid;
    logic [2:0] spawn_dir;
    logic [2:0] heading;
    logic       burst_mode;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int tick_count = 0;
    int hs_tick[$];
    int exp_q[$];

    turret_controller #(
        .DIR_BITS(3), .BURST_LEN(3), .BURST_GAP(4), .COOLDOWN(12)
    ) dut (
        .clk(clk), .rst(rst), .fire(fire), .change_mode(change_mode),
        .rotate(rotate), .rotate_right(rotate_right), .frame_tick(frame_tick),
        .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .spawn_dir(spawn_dir),
        .heading(heading), .burst_mode(burst_mode), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake monitor: every accepted shot must match the next queued heading.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (spawn_valid && spawn_ready) begin
                hs_count++;
                hs_tick.push_back(tick_count);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_shot actual=dir%0d required=none at %0t", spawn_dir, $time);
                end else begin
                    check("shot_dir", 32'(spawn_dir), 32'(exp_q.pop_front()));
                end
            end
            if (frame_tick) tick_count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            tick_once();
            step();
            step();
        end
    endtask

    initial begin
        int hs0;
        int n;
        rst = 1'b1;
        fire = 0; change_mode = 0; rotate = 0; rotate_right = 0; frame_tick = 0; spawn_ready = 0;
        step(); step();

        // Reset values
        check("rst_valid", 32'(spawn_valid), 0);
        check("rst_dir", 32'(spawn_dir), 0);
        check("rst_heading", 32'(heading), 0);
        check("rst_mode", 32'(burst_mode), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();

        // Heading wrap
        rotate = 1; rotate_right = 0; step(); rotate = 0;
        check("wrap_down", 32'(heading), 7);
        check("wrap_busy", 32'(busy), 0);
        check("wrap_valid", 32'(spawn_valid), 0);
        check("wrap_mode", 32'(burst_mode), 0);
        rotate = 1; rotate_right = 1;
        repeat (9) step();
        rotate = 0;
        check("wrap_up", 32'(heading), 0);

        // Single shot with backpressure; rotation during stall must not move spawn_dir
        hs0 = hs_count;
        exp_q.push_back(0);
        fire = 1; step(); fire = 0;
        check("single_valid", 32'(spawn_valid), 1);
        check("single_busy", 32'(busy), 1);
        rotate = 1; rotate_right = 1; step(); rotate = 0;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(spawn_valid), 1);
            check("bp_dir", 32'(spawn_dir), 0);
            step();
        end
        spawn_ready = 1; step();
        check("single_after_hs", 32'(spawn_valid), 0);
        frames(11);
        check("single_cool_busy", 32'(busy), 1);
        tick_once();
        check("single_rearm", 32'(busy), 0);
        check("single_count", 32'(hs_count - hs0), 1);
        check("single_heading", 32'(heading), 1);

        // Burst mode with rotation between shots; fire/change_mode in GAP dropped
        rotate = 1; rotate_right = 0; step(); rotate = 0;
        check("burst_heading0", 32'(heading), 0);
        change_mode = 1; step(); change_mode = 0;
        check("burst_mode_on", 32'(burst_mode), 1);
        hs0 = hs_count;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
        fire = 1; step(); fire = 0;
        check("burst_v1", 32'(spawn_valid), 1);
        step();
        check("burst_after_hs1", 32'(spawn_valid), 0);
        rotate = 1; rotate_right = 1; fire = 1; change_mode = 1; step();
        rotate = 0; fire = 0; change_mode = 0;
        check("burst_rot", 32'(heading), 1);
        check("burst_mode_kept", 32'(burst_mode), 1);
        frames(3);
        check("burst_gap_early", 32'(spawn_valid), 0);
        tick_once();
        check("burst_v2", 32'(spawn_valid), 1);
        check("burst_d2", 32'(spawn_dir), 1);
        step();
        frames(3);
        check("burst_gap2_early", 32'(spawn_valid), 0);
        tick_once();
        check("burst_v3", 32'(spawn_valid), 1);
        step();
        fire = 1; step(); fire = 0;
        frames(11);
        check("burst_cool_busy", 32'(busy), 1);
        tick_once();
        check("burst_rearm", 32'(busy), 0);
        check("burst_count", 32'(hs_count - hs0), 3);
        n = hs_tick.size();
        if (n >= 3) begin
            check("burst_gap_12", 32'(hs_tick[n-2] - hs_tick[n-3]), 4);
            check("burst_gap_23", 32'(hs_tick[n-1] - hs_tick[n-2]), 4);
        end
        check("burst_mode_end", 32'(burst_mode), 1);

        // Dropped fire in SPAWN and COOL; fire on the re-arm edge ignored, next cycle accepted
        change_mode = 1; step(); change_mode = 0;
        check("drop_mode_off", 32'(burst_mode), 0);
        hs0 = hs_count;
        spawn_ready = 0;
        exp_q.push_back(1);
        fire = 1; step();
        step(); fire = 0;
        spawn_ready = 1; step();
        fire = 1; step(); fire = 0;
        frames(11);
        fire = 1; tick_once(); fire = 0;
        check("drop_edge_busy", 32'(busy), 0);
        check("drop_edge_valid", 32'(spawn_valid), 0);
        exp_q.push_back(1);
        fire = 1; step(); fire = 0;
        check("drop_next_busy", 32'(busy), 1);
        step();
        frames(12);
        check("drop_rearm", 32'(busy), 0);
        check("drop_count", 32'(hs_count - hs0), 2);

        // Simultaneous fire + change_mode + rotate in IDLE
        rotate = 1; rotate_right = 1; step(); rotate = 0;
        check("sim_heading0", 32'(heading), 2);
        hs0 = hs_count;
        exp_q.push_back(2);
        fire = 1; change_mode = 1; rotate = 1; rotate_right = 1; step();
        fire = 0; change_mode = 0; rotate = 0;
        check("sim_dir", 32'(spawn_dir), 2);
        check("sim_heading", 32'(heading), 3);
        check("sim_mode", 32'(burst_mode), 1);
        step();
        frames(12);
        check("sim_rearm", 32'(busy), 0);
        check("sim_count", 32'(hs_count - hs0), 1);

        // Reset mid-burst while a shot is stalled
        exp_q.push_back(3);
        fire = 1; step(); fire = 0;
        step();
        spawn_ready = 0;
        frames(4);
        check("mid_valid", 32'(spawn_valid), 1);
        check("mid_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(spawn_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_heading", 32'(heading), 0);
        check("arst_mode", 32'(burst_mode), 0);
        check("arst_dir", 32'(spawn_dir), 0);
        step(); step();
        rst = 1'b0;
        spawn_ready = 1;
        hs0 = hs_count;
        exp_q.push_back(0);
        fire = 1; step(); fire = 0;
        step();
        frames(14);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_count", 32'(hs_count - hs0), 1);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/turret_controller.md
# turret_controller

Consumes the one-cycle action pulses from the input controller and turns them into player-turret behaviour. It tracks the turret heading and the fire mode, single or burst. It paces shots with frame-based gap and cooldown timers, and hands each shot to the projectile engine over a valid/ready spawn handshake. It sits between the input controller and the projectile/sprite logic in the VGA game datapath.

## Interface
- DIR_BITS, 3, heading width; 2^DIR_BITS headings, wrapping.
- BURST_LEN, 3, shots per burst in burst mode (≥1).
- BURST_GAP, 4, frame ticks between shots inside a burst (≥1).
- COOLDOWN, 12, frame ticks after the last shot before re-arm (≥1).

- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- fire  in  1  one-cycle fire request pulse.
- change_mode  in  1  one-cycle mode-toggle pulse.
- rotate  in  1  one-cycle rotate pulse.
- rotate_right  in  1  direction qualifier for rotate: 1 = +1 step, 0 = −1 step.
- frame_tick  in  1  one-cycle pulse per video frame.
- spawn_ready  in  1  projectile engine can accept a shot.
- spawn_valid  out  1  shot offered to the projectile engine.
- spawn_dir  out  DIR_BITS  heading of the offered shot; stable while spawn_valid is high.
- heading  out  DIR_BITS  current turret heading.
- burst_mode  out  1  0 = single shot, 1 = burst.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values: heading=0, burst_mode=0, spawn_valid=0, spawn_dir=0, busy=0, state=IDLE, counters=0.
- Heading:
  - On rotate=1: heading ← heading+1 if rotate_right, else heading−1, modulo 2^DIR_BITS.
  - Wraps: max+1 → 0; 0−1 → max.
  - Rotation is accepted in every state.
- Mode:
  - change_mode toggles burst_mode only in IDLE; it is ignored in all other states.
- FSM states: IDLE, SPAWN, GAP, COOL.
  - IDLE → SPAWN on fire:
    - shots_left ← BURST_LEN if burst_mode, else 1.
    - spawn_dir ← heading, taken before any rotation in the same cycle.
  - SPAWN:
    - spawn_valid=1; spawn_dir is held.
    - On spawn_valid & spawn_ready, shots_left decrements.
    - If it reaches 0: → COOL, cnt ← COOLDOWN.
    - Otherwise: → GAP, cnt ← BURST_GAP.
  - GAP:
    - cnt decrements on each frame_tick.
    - On the tick that takes cnt 1→0: → SPAWN, spawn_dir ← current heading.
  - COOL:
    - cnt decrements on each frame_tick.
    - On the tick that takes cnt 1→0: → IDLE.
- Fire outside IDLE is dropped, not queued.
- fire and change_mode in the same IDLE cycle: the shot count uses the pre-toggle mode, and the toggle also takes effect.
- A frame_tick in the handshake cycle is not counted. Counting starts in the first cycle of GAP/COOL.
- Shot-count and counter widths are sized by $clog2(max parameter + 1); no overflow is possible.

## Timing
- Fire → spawn_valid latency: fire sampled at edge N; spawn_valid=1 after edge N.
- Handshake:
  - Completes on the edge where spawn_valid & spawn_ready are both 1.
  - spawn_valid is 0 after that edge. There is no back-to-back spawn, because the minimum gap is BURST_GAP ticks.
  - spawn_ready is allowed high before valid. Valid is never withdrawn without a handshake.
- Burst cadence: shot k+1 is offered 1 cycle after the BURST_GAP-th frame_tick following shot k's handshake.
- Re-arm: busy drops 1 cycle after the COOLDOWN-th frame_tick following the last handshake.
  - A fire in that same edge cycle is still ignored.
  - A fire on the next cycle is accepted.
- rst asserted mid-operation: every output returns to its reset value immediately (asynchronously), and any in-flight burst is abandoned.
- After rst deasserts, the first active edge behaves as IDLE.

## Test plan
- Reset mid-burst:
  - Stimulus: burst in progress, then assert rst.
  - Required: spawn_valid=0, busy=0, heading=0 and burst_mode=0 without a clock edge.
  - After release, one fire yields exactly 1 shot.
- Heading wrap:
  - Stimulus: from reset, 1 rotate with rotate_right=0.
  - Required: heading=7.
  - Then 9 rotates with rotate_right=1 give heading=0. All other outputs are unaffected.
- Single shot with backpressure:
  - Stimulus: fire with spawn_ready=0 for 5 cycles, then 1.
  - Required: spawn_valid is high from the cycle after fire, spawn_dir is held through the backpressure, and exactly 1 handshake occurs.
  - busy drops 1 cycle after the 12th subsequent frame_tick.
- Burst mode:
  - Stimulus: change_mode, then fire with spawn_ready=1; rotate right once between shot 1 and shot 2.
  - Required: exactly 3 handshakes, each 4 frame_ticks apart, with spawn_dir=0, 1, 1.
  - A change_mode during the burst leaves burst_mode=1.
- Dropped fire:
  - Stimulus: fire pulses during SPAWN, GAP and COOL.
  - Required: no extra shots.
  - fire on the cycle busy falls is ignored; fire one cycle later spawns.
- Simultaneous events in IDLE:
  - Stimulus: fire + change_mode + rotate(right) in the same cycle, from heading=2 and burst_mode=0.
  - Required: 1 shot with spawn_dir=2, heading=3, and burst_mode=1 afterwards.
